// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control FSM for the non-pipelined LEGv8 core. Each instruction is
//   stepped through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. The FSM drives the datapath
//   enables and handshakes with instruction and data memory.
// Ports
//   clk, reset          single rising-edge clock, synchronous active-high reset
//   instruction[31:0]   IR contents; the opcode field is instruction[31:21]
//   alu_zero            ALU zero flag, used by CBZ in EXECUTE
//   imem_req/imem_ack   instruction fetch handshake; ir_write = req & ack
//   dmem_req/dmem_we    data access request, we=1 for store
//   dmem_ack            data access complete
//   alu_en, reg_write, mem_to_reg, pc_write, pc_src   datapath controls
//   halted, fault[1:0]  stop indication: 01 illegal, 10 imem timeout, 11 dmem timeout
//   retired_count       completed instructions, wraps
//   state[2:0]          FETCH=0 DECODE=1 EXECUTE=2 MEMORY=3 WRITEBACK=4 HALT=5
module multicycle_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic             alu_zero,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_write,
  output logic             alu_en,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             pc_write,
  output logic             pc_src,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired_count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
    S_MEMORY = 3'd3, S_WRITEBACK = 3'd4, S_HALT = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LDUR, C_STUR, C_CBZ, C_B, C_ILL
  } class_t;

  // Timeout counter only needs to reach MEM_TIMEOUT.
  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t           state_q;
  class_t           cls_q;
  logic [1:0]       fault_q;
  logic [TW-1:0]    tcnt;
  logic [TW-1:0]    tcnt_inc;
  logic             tmo_hit;
  logic [CNT_W-1:0] retired_q;
  logic             pc_write_i;
  logic             pc_src_i;
  logic             unused_bits;

  assign unused_bits = ^instruction[20:0];

  // LEGv8 11-bit opcode classes on instruction[31:21].
  function automatic class_t classify(input logic [10:0] op);
    class_t c;
    casez (op)
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
      11'b11001010000, 11'b11010011011, 11'b11010011010: c = C_R;
      11'b1001000100?, 11'b1001001000?, 11'b1101001000?,
      11'b1011001000?, 11'b1101000100?:                  c = C_I;
      11'b11111000010:                                   c = C_LDUR;
      11'b11111000000:                                   c = C_STUR;
      11'b10110100???:                                   c = C_CBZ;
      11'b000101?????:                                   c = C_B;
      default:                                           c = C_ILL;
    endcase
    return c;
  endfunction

  // The ack in the cycle the count would reach the limit takes priority over the timeout.
  assign tcnt_inc = tcnt + TW'(1);
  assign tmo_hit  = (MEM_TIMEOUT != 0) && (tcnt_inc == TW'(MEM_TIMEOUT));

  always_comb begin
    pc_write_i = 1'b0;
    pc_src_i   = 1'b0;
    case (state_q)
      S_EXECUTE: begin
        if (cls_q == C_B) begin
          pc_write_i = 1'b1;
          pc_src_i   = 1'b1;
        end else if (cls_q == C_CBZ) begin
          pc_write_i = 1'b1;
          pc_src_i   = alu_zero;
        end
      end
      S_MEMORY:    pc_write_i = (cls_q == C_STUR) && dmem_ack;
      S_WRITEBACK: pc_write_i = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_R;
      fault_q   <= 2'b00;
      tcnt      <= '0;
      retired_q <= '0;
    end else begin
      if (pc_write_i) retired_q <= retired_q + CNT_W'(1);
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            state_q <= S_DECODE;
            tcnt    <= '0;
          end else if (tmo_hit) begin
            state_q <= S_HALT;
            fault_q <= 2'b10;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        S_DECODE: begin
          cls_q <= classify(instruction[31:21]);
          tcnt  <= '0;
          if (classify(instruction[31:21]) == C_ILL) begin
            state_q <= S_HALT;
            fault_q <= 2'b01;
          end else begin
            state_q <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          tcnt <= '0;
          case (cls_q)
            C_B, C_CBZ:     state_q <= S_FETCH;
            C_LDUR, C_STUR: state_q <= S_MEMORY;
            default:        state_q <= S_WRITEBACK;
          endcase
        end
        S_MEMORY: begin
          if (dmem_ack) begin
            state_q <= (cls_q == C_STUR) ? S_FETCH : S_WRITEBACK;
            tcnt    <= '0;
          end else if (tmo_hit) begin
            state_q <= S_HALT;
            fault_q <= 2'b11;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        S_WRITEBACK: begin
          state_q <= S_FETCH;
          tcnt    <= '0;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  // Controls are forced low while reset is sampled so an aborted handshake drops at once.
  assign imem_req      = ~reset && (state_q == S_FETCH);
  assign ir_write      = imem_req && imem_ack;
  assign alu_en        = ~reset && (state_q == S_EXECUTE);
  assign dmem_req      = ~reset && (state_q == S_MEMORY);
  assign dmem_we       = dmem_req && (cls_q == C_STUR);
  assign reg_write     = ~reset && (state_q == S_WRITEBACK);
  assign mem_to_reg    = reg_write && (cls_q == C_LDUR);
  assign pc_write      = ~reset && pc_write_i;
  assign pc_src        = ~reset && pc_src_i;
  assign halted        = ~reset && (state_q == S_HALT);
  assign fault         = reset ? 2'b00 : fault_q;
  assign retired_count = reset ? '0 : retired_q;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      instruction = '0;
  logic             alu_zero = 1'b0;
  logic             imem_ack = 1'b0;
  logic             dmem_ack = 1'b0;
  logic             imem_req, dmem_req, dmem_we, ir_write, alu_en, reg_write;
  logic             mem_to_reg, pc_write, pc_src, halted;
  logic [1:0]       fault;
  logic [CNT_W-1:0] retired_count;
  logic [2:0]       state;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] I_ADDI = {11'b10010001000, 21'h0};
  localparam logic [31:0] I_LDUR = {11'b11111000010, 21'h0};
  localparam logic [31:0] I_STUR = {11'b11111000000, 21'h0};
  localparam logic [31:0] I_B    = {11'b00010100000, 21'h0};
  localparam logic [31:0] I_CBZ  = {11'b10110100000, 21'h0};
  localparam logic [31:0] I_ILL  = 32'h0;

  multicycle_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .alu_zero(alu_zero),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .ir_write(ir_write), .alu_en(alu_en), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .pc_write(pc_write), .pc_src(pc_src), .halted(halted),
    .fault(fault), .retired_count(retired_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each cycle: inputs change on the falling edge, outputs are checked 1 time unit later.
  task automatic rst_pulse();
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Acks the fetch in the next FETCH cycle, then steps through DECODE.
  task automatic do_fetch(input logic [31:0] instr);
    @(negedge clk); imem_ack = 1'b1; instruction = instr; #1;
    chk("fetch_state", 32'(state), 0);
    chk("ir_write", 32'(ir_write), 1);
    @(negedge clk); imem_ack = 1'b0; #1;
    chk("decode_state", 32'(state), 1);
  endtask

  task automatic next_cyc();
    @(negedge clk); #1;
  endtask

  initial begin
    // reset held: every output low
    @(negedge clk); #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_count", 32'(retired_count), 0);
    chk("rst_halted", 32'(halted), 0);

    // 1: ADDI, ack one cycle after req
    @(negedge clk); reset = 1'b0; #1;
    chk("t1_state_f0", 32'(state), 0);
    chk("t1_imem_req", 32'(imem_req), 1);
    chk("t1_ir_write_noack", 32'(ir_write), 0);
    do_fetch(I_ADDI);
    next_cyc();
    chk("t1_exec_state", 32'(state), 2);
    chk("t1_alu_en", 32'(alu_en), 1);
    chk("t1_exec_pcw", 32'(pc_write), 0);
    next_cyc();
    chk("t1_wb_state", 32'(state), 4);
    chk("t1_wb_regw", 32'(reg_write), 1);
    chk("t1_wb_m2r", 32'(mem_to_reg), 0);
    chk("t1_wb_pcw", 32'(pc_write), 1);
    chk("t1_wb_pcsrc", 32'(pc_src), 0);
    chk("t1_count_pre", 32'(retired_count), 0);

    // 2: LDUR, dmem ack after 3 wait cycles
    do_fetch(I_LDUR);
    chk("t1_count", 32'(retired_count), 1);
    next_cyc();
    chk("t2_exec_state", 32'(state), 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); dmem_ack = (i == 3); #1;
      chk("t2_mem_state", 32'(state), 3);
      chk("t2_dmem_req", 32'(dmem_req), 1);
      chk("t2_dmem_we", 32'(dmem_we), 0);
      chk("t2_mem_pcw", 32'(pc_write), 0);
    end
    @(negedge clk); dmem_ack = 1'b0; #1;
    chk("t2_wb_state", 32'(state), 4);
    chk("t2_wb_m2r", 32'(mem_to_reg), 1);
    chk("t2_wb_regw", 32'(reg_write), 1);
    chk("t2_wb_dmem_req", 32'(dmem_req), 0);
    chk("t2_wb_pcw", 32'(pc_write), 1);

    // 3: STUR zero-wait
    do_fetch(I_STUR);
    chk("t2_count", 32'(retired_count), 2);
    next_cyc();
    chk("t3s_exec_regw", 32'(reg_write), 0);
    @(negedge clk); dmem_ack = 1'b1; #1;
    chk("t3s_mem_state", 32'(state), 3);
    chk("t3s_dmem_we", 32'(dmem_we), 1);
    chk("t3s_pcw", 32'(pc_write), 1);
    chk("t3s_pcsrc", 32'(pc_src), 0);
    chk("t3s_regw", 32'(reg_write), 0);
    @(negedge clk); dmem_ack = 1'b0; #1;
    chk("t3s_next_state", 32'(state), 0);
    chk("t3s_regw_after", 32'(reg_write), 0);
    chk("t3s_count", 32'(retired_count), 3);

    // B
    do_fetch(I_B);
    next_cyc();
    chk("t3b_state", 32'(state), 2);
    chk("t3b_pcw", 32'(pc_write), 1);
    chk("t3b_pcsrc", 32'(pc_src), 1);

    // CBZ not taken, then taken
    do_fetch(I_CBZ);
    chk("t3b_count", 32'(retired_count), 4);
    @(negedge clk); alu_zero = 1'b0; #1;
    chk("t3c0_pcw", 32'(pc_write), 1);
    chk("t3c0_pcsrc", 32'(pc_src), 0);
    do_fetch(I_CBZ);
    @(negedge clk); alu_zero = 1'b1; #1;
    chk("t3c1_pcw", 32'(pc_write), 1);
    chk("t3c1_pcsrc", 32'(pc_src), 1);
    @(negedge clk); alu_zero = 1'b0; #1;
    chk("t3c1_state", 32'(state), 0);
    chk("t3c1_count", 32'(retired_count), 6);

    // 6: reset in MEMORY with dmem_req high (and a coincident ack)
    do_fetch(I_LDUR);
    next_cyc();
    next_cyc();
    chk("t6_mem_state", 32'(state), 3);
    chk("t6_dmem_req", 32'(dmem_req), 1);
    @(negedge clk); reset = 1'b1; dmem_ack = 1'b1; #1;
    chk("t6_rst_pcw", 32'(pc_write), 0);
    chk("t6_rst_dmem_req", 32'(dmem_req), 0);
    @(negedge clk); reset = 1'b0; dmem_ack = 1'b0; #1;
    chk("t6_state", 32'(state), 0);
    chk("t6_dmem_req_after", 32'(dmem_req), 0);
    chk("t6_pcw_after", 32'(pc_write), 0);
    chk("t6_count", 32'(retired_count), 0);

    // 5: dmem timeout, ack never arrives
    do_fetch(I_LDUR);
    next_cyc();
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      chk("t5_mem_state", 32'(state), 3);
      chk("t5_mem_req", 32'(dmem_req), 1);
    end
    next_cyc();
    chk("t5_halt_state", 32'(state), 5);
    chk("t5_fault", 32'(fault), 3);
    chk("t5_halted", 32'(halted), 1);
    chk("t5_dmem_req", 32'(dmem_req), 0);
    chk("t5_count", 32'(retired_count), 0);

    // 5 repeat: ack on the 4th wait cycle completes normally
    rst_pulse();
    do_fetch(I_STUR);
    next_cyc();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); dmem_ack = (i == 3); #1;
      chk("t5r_mem_state", 32'(state), 3);
    end
    chk("t5r_pcw", 32'(pc_write), 1);
    @(negedge clk); dmem_ack = 1'b0; #1;
    chk("t5r_state", 32'(state), 0);
    chk("t5r_fault", 32'(fault), 0);
    chk("t5r_count", 32'(retired_count), 1);

    // imem timeout: this FETCH cycle is the first wait cycle
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      chk("tim_fetch_state", 32'(state), 0);
    end
    next_cyc();
    chk("tim_state", 32'(state), 5);
    chk("tim_fault", 32'(fault), 2);

    // 4: illegal opcode
    rst_pulse();
    do_fetch(I_ILL);
    next_cyc();
    chk("t4_state", 32'(state), 5);
    chk("t4_fault", 32'(fault), 1);
    chk("t4_halted", 32'(halted), 1);
    chk("t4_count", 32'(retired_count), 0);
    @(negedge clk); imem_ack = 1'b1; instruction = I_B; #1;
    chk("t4_ir_write", 32'(ir_write), 0);
    chk("t4_imem_req", 32'(imem_req), 0);
    @(negedge clk); imem_ack = 1'b0; #1;
    chk("t4_state_held", 32'(state), 5);
    chk("t4_pcw", 32'(pc_write), 0);

    // retired_count wrap at 2^CNT_W-1
    rst_pulse();
    for (int i = 0; i < 15; i++) begin
      do_fetch(I_B);
      next_cyc();
    end
    next_cyc();
    chk("wrap_max", 32'(retired_count), 15);
    do_fetch(I_B);
    next_cyc();
    chk("wrap_pcw", 32'(pc_write), 1);
    next_cyc();
    chk("wrap_zero", 32'(retired_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
